ddr_rd_checker: RTL and testbench

//  Read-back checker on the user side of ddr_ram_control_mig, downstream of the sequential write

---
 rtl/ddr_rd_checker.sv | 162 ++++++++++++++++
 tb/tb_ddr_rd_checker.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rd_checker.sv
// Read-back checker: issues in-order reads over [START_ADDR, END_ADDR] and compares each
// returned beat against {zeros, addr}, keeping pass/error counts and first-failure capture.
module ddr_rd_checker #(
  parameter int unsigned ADDR_W                 = 25,
  parameter int unsigned DATA_W                 = 256,
  parameter logic [ADDR_W-1:0] START_ADDR       = 25'd0,
  parameter logic [ADDR_W-1:0] END_ADDR         = 25'h1FF_FFFF,
  parameter int unsigned OUTST_DEPTH            = 16
) (
  input  logic              ui_clk,
  input  logic              cpu_resetn,
  input  logic              start,
  input  logic              rd_busy,
  input  logic              rd_data_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              busy,
  output logic              done,
  output logic [31:0]       pass_cnt,
  output logic [31:0]       err_cnt,
  output logic              err_flag,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data,
  output logic              spurious
);

  localparam int unsigned PTR_W = (OUTST_DEPTH > 1) ? $clog2(OUTST_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   iptr_q, iptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    fill_q, fill_d;
  logic [31:0]         pass_cnt_q, pass_cnt_d;
  logic [31:0]         err_cnt_q, err_cnt_d;
  logic                err_flag_q, err_flag_d;
  logic                spurious_q, spurious_d;
  logic [ADDR_W-1:0]   first_err_addr_q, first_err_addr_d;
  logic [DATA_W-1:0]   first_err_data_q, first_err_data_d;

  logic [ADDR_W-1:0]   fifo_mem [OUTST_DEPTH];
  logic                fifo_full, fifo_empty, pop, start_ok;
  logic [ADDR_W-1:0]   exp_addr;

  assign fifo_full  = (fill_q == CNT_W'(OUTST_DEPTH));
  assign fifo_empty = (fill_q == '0);
  assign exp_addr   = fifo_mem[rd_ptr_q];
  assign rd_en      = (state_q == ST_RUN) & ~rd_busy & ~fifo_full;
  assign pop        = rd_data_valid & ~fifo_empty & (state_q != ST_IDLE);
  assign start_ok   = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));

  // Next-state, issue, FIFO bookkeeping and result checking
  always_comb begin
    state_d          = state_q;
    iptr_d           = iptr_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    fill_d           = fill_q;
    pass_cnt_d       = pass_cnt_q;
    err_cnt_d        = err_cnt_q;
    err_flag_d       = err_flag_q;
    spurious_d       = spurious_q;
    first_err_addr_d = first_err_addr_q;
    first_err_data_d = first_err_data_q;

    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN: begin
        if (rd_en) begin
          // Pointer parks on END_ADDR so it can never wrap
          if (iptr_q == END_ADDR) state_d = ST_DRAIN;
          else                    iptr_d  = iptr_q + ADDR_W'(1);
        end
      end
      ST_DRAIN: if (fifo_empty) state_d = ST_DONE;
      ST_DONE:  if (start) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase

    if (rd_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({rd_en, pop})
      2'b10:   fill_d = fill_q + CNT_W'(1);
      2'b01:   fill_d = fill_q - CNT_W'(1);
      default: fill_d = fill_q;
    endcase

    if (rd_data_valid && (state_q != ST_IDLE)) begin
      if (fifo_empty) begin
        spurious_d = 1'b1;
      end else if (rd_data == DATA_W'(exp_addr)) begin
        if (pass_cnt_q != 32'hFFFF_FFFF) pass_cnt_d = pass_cnt_q + 32'd1;
      end else begin
        if (err_cnt_q != 32'hFFFF_FFFF) err_cnt_d = err_cnt_q + 32'd1;
        err_flag_d = 1'b1;
        if (!err_flag_q) begin
          first_err_addr_d = exp_addr;
          first_err_data_d = rd_data;
        end
      end
    end

    // A new pass wipes all results of the previous one
    if (start_ok) begin
      iptr_d           = START_ADDR;
      pass_cnt_d       = '0;
      err_cnt_d        = '0;
      err_flag_d       = 1'b0;
      spurious_d       = 1'b0;
      first_err_addr_d = '0;
      first_err_data_d = '0;
    end
  end

  always_ff @(posedge ui_clk) begin
    if (!cpu_resetn) begin
      state_q          <= ST_IDLE;
      iptr_q           <= START_ADDR;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      fill_q           <= '0;
      pass_cnt_q       <= '0;
      err_cnt_q        <= '0;
      err_flag_q       <= 1'b0;
      spurious_q       <= 1'b0;
      first_err_addr_q <= '0;
      first_err_data_q <= '0;
    end else begin
      state_q          <= state_d;
      iptr_q           <= iptr_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      fill_q           <= fill_d;
      pass_cnt_q       <= pass_cnt_d;
      err_cnt_q        <= err_cnt_d;
      err_flag_q       <= err_flag_d;
      spurious_q       <= spurious_d;
      first_err_addr_q <= first_err_addr_d;
      first_err_data_q <= first_err_data_d;
    end
  end

  // Expected-address storage; contents are don't-care once the pointers are reset
  always_ff @(posedge ui_clk) begin
    if (rd_en) fifo_mem[wr_ptr_q] <= iptr_q;
  end

  assign rd_addr        = iptr_q;
  assign busy           = (state_q == ST_RUN) | (state_q == ST_DRAIN);
  assign done           = (state_q == ST_DONE);
  assign pass_cnt       = pass_cnt_q;
  assign err_cnt        = err_cnt_q;
  assign err_flag       = err_flag_q;
  assign spurious       = spurious_q;
  assign first_err_addr = first_err_addr_q;
  assign first_err_data = first_err_data_q;

endmodule

// File: tb/tb_ddr_rd_checker.sv
// Bench for ddr_rd_checker: memory responder model, request scoreboard and directed passes.
module tb_ddr_rd_checker;

  logic         clk = 1'b0;
  logic         cpu_resetn, start, rd_busy, rd_data_valid;
  logic [255:0] rd_data;
  logic         rd_en, busy, done, err_flag, spurious;
  logic [24:0]  rd_addr, first_err_addr;
  logic [31:0]  pass_cnt, err_cnt;
  logic [255:0] first_err_data;

  int vectors = 0;
  int errs    = 0;
  int cyc     = 0;
  int n_req   = 0;
  int hold_until = 0;
  logic inj_spur = 1'b0, corrupt = 1'b0, busy_toggle = 1'b0;

  logic [24:0] exp_q[$];
  int          req_cyc_q[$];
  logic [24:0] ret_addr_q[$];
  int          ret_due_q[$];

  always #5 clk = ~clk;

  ddr_rd_checker #(
    .ADDR_W(25), .DATA_W(256), .START_ADDR(25'd0), .END_ADDR(25'd7), .OUTST_DEPTH(4)
  ) dut (
    .ui_clk(clk), .cpu_resetn(cpu_resetn), .start(start), .rd_busy(rd_busy),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .busy(busy), .done(done), .pass_cnt(pass_cnt), .err_cnt(err_cnt), .err_flag(err_flag),
    .first_err_addr(first_err_addr), .first_err_data(first_err_data), .spurious(spurious)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory model: returns {0,addr} three cycles after acceptance, in order
  initial begin
    logic [24:0] a;
    rd_data_valid = 1'b0;
    rd_data       = '0;
    rd_busy       = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (!cpu_resetn) begin
        ret_addr_q.delete();
        ret_due_q.delete();
      end
      rd_busy       = busy_toggle ? ((cyc % 2) == 1) : 1'b0;
      rd_data_valid = 1'b0;
      rd_data       = '0;
      if (inj_spur) begin
        rd_data_valid = 1'b1;
      end else if (ret_addr_q.size() > 0 && cyc >= hold_until && ret_due_q[0] <= cyc) begin
        a = ret_addr_q.pop_front();
        void'(ret_due_q.pop_front());
        rd_data_valid = 1'b1;
        rd_data       = (corrupt && a == 25'd5) ? 256'h1234 : 256'(a);
      end
      #1;
      if (cpu_resetn && rd_en) begin
        ret_addr_q.push_back(rd_addr);
        ret_due_q.push_back(cyc + 3);
      end
    end
  end

  // Monitor: every request must match the next expected address and respect rd_busy
  initial begin
    logic [24:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (!cpu_resetn) begin
        exp_q.delete();
      end else if (rd_en) begin
        n_req++;
        req_cyc_q.push_back(cyc);
        chk("rd_en_while_busy", 256'(rd_busy), 256'd0);
        if (exp_q.size() == 0) begin
          vectors++;
          errs++;
          $display("FAIL unexpected_req: got addr %0h expected none", rd_addr);
        end else begin
          e = exp_q.pop_front();
          chk("rd_addr", 256'(rd_addr), 256'(e));
        end
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_window();
    for (int i = 0; i < 8; i++) exp_q.push_back(25'(i));
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(name, 256'(done), 256'd1);
    chk({name, "_all_issued"}, 256'(exp_q.size()), 256'd0);
  endtask

  task automatic chk_results(input string name, input int p, input int e, input logic f);
    chk({name, "_pass_cnt"}, 256'(pass_cnt), 256'(p));
    chk({name, "_err_cnt"},  256'(err_cnt),  256'(e));
    chk({name, "_err_flag"}, 256'(err_flag), 256'(f));
  endtask

  initial begin
    int base;
    int n;
    cpu_resetn = 1'b0;
    start      = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 256'(busy), 256'd0);
    chk("rst_done", 256'(done), 256'd0);
    chk("rst_rd_en", 256'(rd_en), 256'd0);
    chk_results("rst", 0, 0, 1'b0);
    chk("rst_spurious", 256'(spurious), 256'd0);
    cpu_resetn = 1'b1;
    @(negedge clk);

    // Clean pass, requests back-to-back
    push_window();
    base = req_cyc_q.size();
    pulse_start();
    wait_done("clean_done");
    chk_results("clean", 8, 0, 1'b0);
    chk("clean_spacing", 256'(req_cyc_q[base + 7] - req_cyc_q[base]), 256'd7);
    chk("clean_spurious", 256'(spurious), 256'd0);

    // Beat for address 5 corrupted
    corrupt = 1'b1;
    push_window();
    pulse_start();
    wait_done("corrupt_done");
    chk_results("corrupt", 7, 1, 1'b1);
    chk("corrupt_first_addr", 256'(first_err_addr), 256'd5);
    chk("corrupt_first_data", first_err_data, 256'h1234);
    corrupt = 1'b0;

    // Returns withheld: only OUTST_DEPTH reads may be outstanding
    push_window();
    base = n_req;
    hold_until = cyc + 20;
    pulse_start();
    repeat (12) @(negedge clk);
    chk("hold_issued", 256'(n_req - base), 256'd4);
    chk("hold_rd_en", 256'(rd_en), 256'd0);
    wait_done("hold_done");
    chk_results("hold", 8, 0, 1'b0);
    chk("hold_first_addr_clear", 256'(first_err_addr), 256'd0);

    // rd_busy alternating
    busy_toggle = 1'b1;
    push_window();
    base = n_req;
    pulse_start();
    wait_done("toggle_done");
    busy_toggle = 1'b0;
    chk_results("toggle", 8, 0, 1'b0);
    chk("toggle_issued", 256'(n_req - base), 256'd8);

    // Stray beat in DONE
    inj_spur = 1'b1;
    @(negedge clk);
    inj_spur = 1'b0;
    @(negedge clk);
    chk("spur_flag", 256'(spurious), 256'd1);
    chk("spur_done", 256'(done), 256'd1);
    chk_results("spur", 8, 0, 1'b0);

    // Reset after 3 accepted reads; a stray beat before the first push sets spurious
    push_window();
    base = n_req;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    inj_spur = 1'b1;
    @(negedge clk);
    inj_spur = 1'b0;
    n = 0;
    while ((n_req - base) < 3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mid_spurious", 256'(spurious), 256'd1);
    cpu_resetn = 1'b0;
    @(negedge clk);
    cpu_resetn = 1'b1;
    chk("mid_rst_busy", 256'(busy), 256'd0);
    chk("mid_rst_done", 256'(done), 256'd0);
    chk("mid_rst_spurious", 256'(spurious), 256'd0);
    chk("mid_rst_rd_addr", 256'(rd_addr), 256'd0);
    chk_results("mid_rst", 0, 0, 1'b0);
    @(negedge clk);
    chk("mid_idle_rd_en", 256'(rd_en), 256'd0);
    push_window();
    pulse_start();
    wait_done("after_rst_done");
    chk_results("after_rst", 8, 0, 1'b0);
    chk("after_rst_spurious", 256'(spurious), 256'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
